cache_port_arbiter: RTL
=======================

# cache_port_arbiter

Shares the single-ported CacheMemory between two requesters: the instruction-fetch path (reads) and the refill path from the next memory level (line writes). Each cycle it picks at most one request, registers it onto CacheMemory's fetch or update inputs, and inserts the mandatory one-cycle bubble whenever the command stream switches between read and write. Refills have priority; a streak limit bounds fetch starvation.

## Interface
- TAG_W, 51, tag width
- INDEX_W, 8, set index width
- OFFSET_W, 5, byte offset width
- LINE_W, 256, cacheline width
- MAX_STREAK, 4, max consecutive refill grants while a fetch waits (1..15)
- clock_i  in  1  clock, rising edge
- reset_i  in  1  reset, asynchronous, active-low
- fetchValid_i  in  1  fetch request present
- fetchReady_o  out  1  fetch accepted this cycle (combinational)
- fetchTag_i / fetchIndex_i / fetchOffset_i  in  TAG_W / INDEX_W / OFFSET_W  fetch address
- refillValid_i  in  1  refill request present
- refillReady_o  out  1  refill accepted this cycle (combinational)
- refillLine_i  in  LINE_W  line data
- refillTag_i / refillIndex_i / refillOffset_i  in  TAG_W / INDEX_W / OFFSET_W  refill address
- fetchEnable_o  out  1  to CacheMemory fetchEnable_i, registered
- tag_o / index_o / offset_o  out  TAG_W / INDEX_W / OFFSET_W  to CacheMemory tag_i/index_i/offset_i, registered
- updateEnable_o  out  1  to CacheMemory updateEnable_i, registered
- newCacheline_o / newTag_o / newIndex_o / newOffset_o  out  LINE_W / TAG_W / INDEX_W / OFFSET_W  to CacheMemory update inputs, registered
- bubble_o  out  1  registered; high in a cycle where a turnaround bubble is being taken
- All vectors numbered [0:N-1], bit 0 = MSB.

## Operation
- State = type of command issued in the previous cycle: IDLE (none), RD (read), WR (write).
- forceFetch = fetchValid_i && streak == MAX_STREAK.
- Selection (combinational): W if refillValid_i && !forceFetch; else R if fetchValid_i; else none.
- Compatibility: IDLE accepts R or W; RD accepts only R; WR accepts only W.
- Compatible selection -> grant: matching ready_o high; on the edge load the matching output group, pulse its enable for one cycle; next state RD or WR.
- Incompatible selection -> bubble: no ready, both enables 0 next cycle, bubble_o=1 next cycle, next state IDLE. The selection is re-evaluated in IDLE (inputs may change; no request is latched).
- No selection -> next state IDLE, enables 0.
- Never both readies high in one cycle; never both enables high in one cycle.
- streak (4-bit): +1 on each W grant while fetchValid_i=1 (saturates at MAX_STREAK); cleared on any R grant or any cycle with fetchValid_i=0.
- Address/data outputs hold last granted values while the enable is low; the other group is not disturbed by a grant.
- Requesters must hold valid and payload stable until ready is seen.

## Timing
- Reset (async assert, sync-free release): state IDLE, streak 0, all registered outputs 0 (enables, bubble_o, address/data fields).
- Latency: request accepted at edge N appears on cache-side outputs in cycle N+1; CacheMemory read data follows one cycle later per its own timing.
- Same-type back-to-back: one grant per cycle, full throughput.
- Type switch: exactly one bubble cycle between last read enable and first write enable, and vice versa.
- Reset asserted mid-operation: in-flight enable pulses dropped immediately; no request counted as accepted after reset falls.
- Simultaneous first requests from IDLE: refill wins (streak 0).

## Test plan
- Reset: drive reset_i=0 with both valid high -> all outputs 0, no ready; release -> refill granted first cycle, updateEnable_o=1 next cycle with newIndex_o=refillIndex_i.
- Read burst: fetchValid_i held, indices 0,1,2 -> fetchReady_o three consecutive cycles, fetchEnable_o high three cycles, index_o=0,1,2, bubble_o=0.
- Write->read: refill index 0 line 256'hFFFFFFFF_..._88888888, then fetch index 0 tag 55 offset 7 -> updateEnable_o cycle N+1, bubble_o=1 cycle N+2, fetchEnable_o cycle N+3 with tag_o=55, offset_o=7.
- Read->write: fetch index 0 granted, then refill index 1 -> one bubble cycle, then updateEnable_o with newIndex_o=1.
- Starvation: both valid continuously, MAX_STREAK=4 -> 4 writes, bubble, 1 read, bubble, writes resume; repeating pattern.
- Mid-burst reset: assert reset_i during write burst -> updateEnable_o falls same cycle asynchronously, state IDLE, streak 0 after release.

Source files
------------

// File: rtl/cache_port_arbiter_if.sv
// Request/grant and CacheMemory-side signals of the cache port arbiter.
// Names carry the arbiter's point of view: _i is an arbiter input, _o an arbiter output.
interface cache_port_arbiter_if #(
    parameter int TAG_W    = 51,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 5,
    parameter int LINE_W   = 256
);
    // Handshake: a requester raises valid with a stable payload and holds both until the
    // cycle its ready is high; the request is taken on that cycle's rising edge.
    logic                  fetchValid_i;
    logic                  fetchReady_o;
    logic [0:TAG_W-1]      fetchTag_i;
    logic [0:INDEX_W-1]    fetchIndex_i;
    logic [0:OFFSET_W-1]   fetchOffset_i;

    logic                  refillValid_i;
    logic                  refillReady_o;
    logic [0:LINE_W-1]     refillLine_i;
    logic [0:TAG_W-1]      refillTag_i;
    logic [0:INDEX_W-1]    refillIndex_i;
    logic [0:OFFSET_W-1]   refillOffset_i;

    logic                  fetchEnable_o;
    logic [0:TAG_W-1]      tag_o;
    logic [0:INDEX_W-1]    index_o;
    logic [0:OFFSET_W-1]   offset_o;

    logic                  updateEnable_o;
    logic [0:LINE_W-1]     newCacheline_o;
    logic [0:TAG_W-1]      newTag_o;
    logic [0:INDEX_W-1]    newIndex_o;
    logic [0:OFFSET_W-1]   newOffset_o;

    logic                  bubble_o;
    // Debug view: state (0 IDLE, 1 RD, 2 WR) and refill streak counter.
    logic [0:1]            dbgState_o;
    logic [0:3]            dbgStreak_o;

    modport slave (
        input  fetchValid_i, fetchTag_i, fetchIndex_i, fetchOffset_i,
        input  refillValid_i, refillLine_i, refillTag_i, refillIndex_i, refillOffset_i,
        output fetchReady_o, refillReady_o,
        output fetchEnable_o, tag_o, index_o, offset_o,
        output updateEnable_o, newCacheline_o, newTag_o, newIndex_o, newOffset_o,
        output bubble_o, dbgState_o, dbgStreak_o
    );

    modport master (
        output fetchValid_i, fetchTag_i, fetchIndex_i, fetchOffset_i,
        output refillValid_i, refillLine_i, refillTag_i, refillIndex_i, refillOffset_i,
        input  fetchReady_o, refillReady_o,
        input  fetchEnable_o, tag_o, index_o, offset_o,
        input  updateEnable_o, newCacheline_o, newTag_o, newIndex_o, newOffset_o,
        input  bubble_o, dbgState_o, dbgStreak_o
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Arbitrates instruction fetches (reads) and line refills (writes) onto single-ported
// CacheMemory, with a one-cycle bubble on read/write turnaround and a fetch starvation bound.
module cache_port_arbiter #(
    parameter int MAX_STREAK = 4
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    cache_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_STREAK);

    state_t     r_state;
    logic [3:0] r_streak;

    logic w_force_fetch;
    logic w_sel_wr;
    logic w_sel_rd;
    logic w_grant_wr;
    logic w_grant_rd;
    logic w_turnaround;

    // Readies are gated by reset so nothing is accepted while reset is held.
    always_comb begin
        w_force_fetch = bus.fetchValid_i && (r_streak == STREAK_LIMIT);
        w_sel_wr      = bus.refillValid_i && !w_force_fetch;
        w_sel_rd      = !w_sel_wr && bus.fetchValid_i;
        w_grant_wr    = reset_i && w_sel_wr && (r_state != S_RD);
        w_grant_rd    = reset_i && w_sel_rd && (r_state != S_WR);
        w_turnaround  = (w_sel_wr && (r_state == S_RD)) || (w_sel_rd && (r_state == S_WR));
    end

    assign bus.fetchReady_o  = w_grant_rd;
    assign bus.refillReady_o = w_grant_wr;
    assign bus.dbgState_o    = r_state;
    assign bus.dbgStreak_o   = r_streak;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state            <= S_IDLE;
            r_streak           <= 4'd0;
            bus.fetchEnable_o  <= 1'b0;
            bus.tag_o          <= '0;
            bus.index_o        <= '0;
            bus.offset_o       <= '0;
            bus.updateEnable_o <= 1'b0;
            bus.newCacheline_o <= '0;
            bus.newTag_o       <= '0;
            bus.newIndex_o     <= '0;
            bus.newOffset_o    <= '0;
            bus.bubble_o       <= 1'b0;
        end else begin
            bus.fetchEnable_o  <= w_grant_rd;
            bus.updateEnable_o <= w_grant_wr;
            bus.bubble_o       <= w_turnaround;

            if (w_grant_rd) begin
                bus.tag_o    <= bus.fetchTag_i;
                bus.index_o  <= bus.fetchIndex_i;
                bus.offset_o <= bus.fetchOffset_i;
            end
            if (w_grant_wr) begin
                bus.newCacheline_o <= bus.refillLine_i;
                bus.newTag_o       <= bus.refillTag_i;
                bus.newIndex_o     <= bus.refillIndex_i;
                bus.newOffset_o    <= bus.refillOffset_i;
            end

            if (w_grant_wr)      r_state <= S_WR;
            else if (w_grant_rd) r_state <= S_RD;
            else                 r_state <= S_IDLE;

            // The streak only measures refill grants taken while a fetch is waiting.
            if (!bus.fetchValid_i || w_grant_rd)
                r_streak <= 4'd0;
            else if (w_grant_wr && (r_streak != STREAK_LIMIT))
                r_streak <= r_streak + 4'd1;
        end
    end
endmodule
